// File: rtl/hazard_fwd_ctrl.sv
// E/M/W destination tracking, D/E/M forwarding selects and the D-stage stall/flush; all outputs are combinational.
// Optional `HAZARD_MULDIV_EN adds the HI/LO busy-counter interlock.
module hazard_fwd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic [1:0] tnew_D,
  input  logic [1:0] src_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic       flush_E,
  output logic [2:0] fwd_rs_D,
  output logic [2:0] fwd_rt_D,
  output logic [2:0] fwd_rs_E,
  output logic [2:0] fwd_rt_E,
  output logic [2:0] fwd_rt_M
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_PC8 = 2'd2;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [1:0] src;
  } stage_t;

  stage_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic   data_stall;
  logic   unused_bits;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
    return (r != 5'd0) && (r == a3);
  endfunction

  // Only the youngest matching stage decides, so an older write never masks a newer one.
  function automatic logic need_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input logic [4:0] ea3, input logic [1:0] etn,
                                      input logic [4:0] ma3, input logic [1:0] mtn,
                                      input logic [4:0] wa3, input logic [1:0] wtn);
    logic s;
    s = 1'b0;
    if (hit(r, ea3))      s = (etn > tuse);
    else if (hit(r, ma3)) s = (mtn > tuse);
    else if (hit(r, wa3)) s = (wtn > tuse);
    return s;
  endfunction

  function automatic logic [2:0] sel_d(input logic [4:0] r,
                                       input logic [4:0] ea3, input logic [1:0] etn, input logic [1:0] esrc,
                                       input logic [4:0] ma3, input logic [1:0] mtn, input logic [1:0] msrc,
                                       input logic [4:0] wa3, input logic [1:0] wsrc);
    logic [2:0] s;
    s = 3'b000;
    if (hit(r, ea3)) begin
      if (etn == 2'd0 && esrc == SRC_PC8) s = 3'b001;
    end else if (hit(r, ma3)) begin
      if (mtn == 2'd0 && msrc == SRC_ALU)      s = 3'b010;
      else if (mtn == 2'd0 && msrc == SRC_PC8) s = 3'b011;
    end else if (hit(r, wa3)) begin
      s = (wsrc == SRC_PC8) ? 3'b101 : 3'b100;
    end
    return s;
  endfunction

  function automatic logic [2:0] sel_e(input logic [4:0] r,
                                       input logic [4:0] ma3, input logic [1:0] mtn, input logic [1:0] msrc,
                                       input logic [4:0] wa3, input logic [1:0] wsrc);
    logic [2:0] s;
    s = 3'b000;
    if (hit(r, ma3)) begin
      if (mtn == 2'd0 && msrc == SRC_ALU)      s = 3'b001;
      else if (mtn == 2'd0 && msrc == SRC_PC8) s = 3'b010;
    end else if (hit(r, wa3)) begin
      s = (wsrc == SRC_PC8) ? 3'b100 : 3'b011;
    end
    return s;
  endfunction

  always_comb begin
    data_stall = need_stall(rs_D, tuse_rs_D, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew)
               | need_stall(rt_D, tuse_rt_D, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
    fwd_rs_D   = sel_d(rs_D, e_q.a3, e_q.tnew, e_q.src, m_q.a3, m_q.tnew, m_q.src, w_q.a3, w_q.src);
    fwd_rt_D   = sel_d(rt_D, e_q.a3, e_q.tnew, e_q.src, m_q.a3, m_q.tnew, m_q.src, w_q.a3, w_q.src);
    fwd_rs_E   = sel_e(e_q.rs, m_q.a3, m_q.tnew, m_q.src, w_q.a3, w_q.src);
    fwd_rt_E   = sel_e(e_q.rt, m_q.a3, m_q.tnew, m_q.src, w_q.a3, w_q.src);
    fwd_rt_M   = 3'b000;
    if (hit(m_q.rt, w_q.a3)) fwd_rt_M = (w_q.src == SRC_PC8) ? 3'b010 : 3'b001;
  end

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs   = rs_D;
      e_d.rt   = rt_D;
      e_d.a3   = a3_D;
      e_d.tnew = tnew_D;
      e_d.src  = src_D;
    end
    m_d      = e_q;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    w_d      = m_q;
    w_d.tnew = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZARD_MULDIV_EN
  logic       md_start_e_q, md_div_e_q;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_stall;

  // Counter loads as the start leaves E, so the E cycle itself is covered by md_start_e_q.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_e_q)           md_cnt_d = md_div_e_q ? 4'd10 : 4'd5;
    else if (md_cnt_q != 4'd0)  md_cnt_d = md_cnt_q - 4'd1;
  end

  assign md_stall = md_use_D && ((md_cnt_q != 4'd0) || md_start_e_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_start_e_q <= 1'b0;
      md_div_e_q   <= 1'b0;
      md_cnt_q     <= 4'd0;
    end else begin
      md_start_e_q <= md_start_D && !stall;
      md_div_e_q   <= md_div_D && !stall;
      md_cnt_q     <= md_cnt_d;
    end
  end

  assign stall       = data_stall | md_stall;
  assign unused_bits = ^{m_q.rs, w_q.rs, w_q.rt};
`else
  assign stall       = data_stall;
  assign unused_bits = ^{m_q.rs, w_q.rs, w_q.rt, md_start_D, md_div_D, md_use_D};
`endif

  assign flush_E = stall;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed and random checks of hazard_fwd_ctrl against an in-flight instruction list model.
module tb_hazard_fwd_ctrl;

  logic       clk, reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, src_D;
  logic       md_start_D, md_div_D, md_use_D;
  logic       stall, flush_E;
  logic [2:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  hazard_fwd_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .tnew_D(tnew_D), .src_D(src_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .stall(stall), .flush_E(flush_E),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Each in-flight instruction keeps its original Tnew; age 0/1/2 = E/M/W.
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    int         tnew;
    int         src;
    bit         mds;
    bit         mdd;
  } ins_t;

  ins_t pipe [3];
`ifdef HAZARD_MULDIV_EN
  int md_busy;
`endif

  function automatic ins_t bubble();
    ins_t b;
    b.rs = 0; b.rt = 0; b.a3 = 0; b.tnew = 0; b.src = 0; b.mds = 0; b.mdd = 0;
    return b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
`ifdef HAZARD_MULDIV_EN
    md_busy = 0;
`endif
  endfunction

  function automatic int rem(int age);
    int v;
    v = pipe[age].tnew - age;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int youngest(logic [4:0] r, int from);
    for (int a = from; a < 3; a++)
      if (r != 5'd0 && pipe[a].a3 == r) return a;
    return -1;
  endfunction

  function automatic bit op_stall(logic [4:0] r, logic [1:0] tuse);
    int a;
    a = youngest(r, 0);
    return (a >= 0) && (rem(a) > int'(tuse));
  endfunction

  function automatic bit model_stall();
    bit s;
    s = op_stall(rs_D, tuse_rs_D) || op_stall(rt_D, tuse_rt_D);
`ifdef HAZARD_MULDIV_EN
    if (md_use_D && (md_busy > 0 || pipe[0].mds)) s = 1'b1;
`endif
    return s;
  endfunction

  function automatic logic [2:0] exp_d(logic [4:0] r);
    int a;
    a = youngest(r, 0);
    if (a == 0) return (rem(0) == 0 && pipe[0].src == 2) ? 3'b001 : 3'b000;
    if (a == 1) begin
      if (rem(1) != 0)      return 3'b000;
      if (pipe[1].src == 0) return 3'b010;
      if (pipe[1].src == 2) return 3'b011;
      return 3'b000;
    end
    if (a == 2) return (pipe[2].src == 2) ? 3'b101 : 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_e(logic [4:0] r);
    int a;
    a = youngest(r, 1);
    if (a == 1) begin
      if (rem(1) != 0)      return 3'b000;
      if (pipe[1].src == 0) return 3'b001;
      if (pipe[1].src == 2) return 3'b010;
      return 3'b000;
    end
    if (a == 2) return (pipe[2].src == 2) ? 3'b100 : 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_m(logic [4:0] r);
    if (youngest(r, 2) == 2) return (pipe[2].src == 2) ? 3'b010 : 3'b001;
    return 3'b000;
  endfunction

  function automatic void model_adv(bit st);
`ifdef HAZARD_MULDIV_EN
    if (pipe[0].mds)      md_busy = pipe[0].mdd ? 10 : 5;
    else if (md_busy > 0) md_busy = md_busy - 1;
`endif
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (st) pipe[0] = bubble();
    else begin
      pipe[0].rs   = rs_D;
      pipe[0].rt   = rt_D;
      pipe[0].a3   = a3_D;
      pipe[0].tnew = int'(tnew_D);
      pipe[0].src  = int'(src_D);
      pipe[0].mds  = md_start_D;
      pipe[0].mdd  = md_div_D;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit es;
    es = model_stall();
    chk({tag, " stall"},    8'(stall),    8'(es));
    chk({tag, " flush_E"},  8'(flush_E),  8'(es));
    chk({tag, " fwd_rs_D"}, 8'(fwd_rs_D), 8'(exp_d(rs_D)));
    chk({tag, " fwd_rt_D"}, 8'(fwd_rt_D), 8'(exp_d(rt_D)));
    chk({tag, " fwd_rs_E"}, 8'(fwd_rs_E), 8'(exp_e(pipe[0].rs)));
    chk({tag, " fwd_rt_E"}, 8'(fwd_rt_E), 8'(exp_e(pipe[0].rt)));
    chk({tag, " fwd_rt_M"}, 8'(fwd_rt_M), 8'(exp_m(pipe[1].rt)));
  endtask

  task automatic tick();
    bit st;
    st = model_stall();
    @(posedge clk);
    if (!reset) model_clear();
    else        model_adv(st);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] a3, input logic [1:0] tn,
                       input logic [1:0] sr);
    rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
    a3_D = a3; tnew_D = tn; src_D = sr;
    md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic i_nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0);
  endtask

  function automatic logic [4:0] pick();
    logic [4:0] r;
    case ($urandom_range(0, 3))
      0: r = 5'd0;
      1: r = 5'd1;
      2: r = 5'd2;
      default: r = 5'd31;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b0;
    set_d(5'd3, 5'd3, 2'd0, 2'd0, 5'd3, 2'd2, 2'd1);
    model_clear();
    #2; check_all("reset"); chk("reset stall", 8'(stall), 8'd0);
    tick();
    i_nop(); #2 reset = 1'b1;
    check_all("release"); tick();

    // addu $3 ; addu reading $3
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 2'd0); #2 check_all("addu3"); tick();
    set_d(5'd3, 5'd0, 2'd1, 2'd1, 5'd4, 2'd1, 2'd0); #2 check_all("addu_use");
    chk("addu_use stall", 8'(stall), 8'd0); tick();
    i_nop(); #2 check_all("addu_E"); chk("addu_E fwd_rs_E", 8'(fwd_rs_E), 8'd1); tick();

    // lw $5 ; beq $5,$0
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 2'd1); #2 check_all("lw5"); tick();
    set_d(5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0); #2 check_all("beq1");
    chk("beq1 stall", 8'(stall), 8'd1); chk("beq1 flush", 8'(flush_E), 8'd1); tick();
    #2 check_all("beq2"); chk("beq2 stall", 8'(stall), 8'd1); tick();
    #2 check_all("beq3"); chk("beq3 stall", 8'(stall), 8'd0);
    chk("beq3 fwd_rs_D", 8'(fwd_rs_D), 8'd4); tick();

    // jal ; jr $31, then with one nop between
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd2); #2 check_all("jal_a"); tick();
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0); #2 check_all("jr_a");
    chk("jr_a fwd_rs_D", 8'(fwd_rs_D), 8'd1); chk("jr_a stall", 8'(stall), 8'd0); tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd2); #2 check_all("jal_b"); tick();
    i_nop(); #2 check_all("jal_nop"); tick();
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0); #2 check_all("jr_b");
    chk("jr_b fwd_rs_D", 8'(fwd_rs_D), 8'd3); chk("jr_b stall", 8'(stall), 8'd0); tick();

    // lw $2 ; sw $2,0($4)
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd2, 2'd2, 2'd1); #2 check_all("lw2"); tick();
    set_d(5'd4, 5'd2, 2'd1, 2'd2, 5'd0, 2'd0, 2'd0); #2 check_all("sw");
    chk("sw stall", 8'(stall), 8'd0); tick();
    i_nop(); #2 check_all("sw_E"); tick();
    i_nop(); #2 check_all("sw_M"); chk("sw_M fwd_rt_M", 8'(fwd_rt_M), 8'd1); tick();

    // $0 destination with Tnew 2
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 2'd1); #2 check_all("zero_wr"); tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0); #2 check_all("zero_rd");
    chk("zero_rd stall", 8'(stall), 8'd0);
    chk("zero_rd fwd_rs_D", 8'(fwd_rs_D), 8'd0); chk("zero_rd fwd_rt_D", 8'(fwd_rt_D), 8'd0); tick();

    // asynchronous reset in the middle of a load-use stall
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 2'd1); #2 check_all("arst_lw"); tick();
    set_d(5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0); #2 check_all("arst_beq");
    chk("arst_beq stall", 8'(stall), 8'd1);
    #1 reset = 1'b0; model_clear();
    #1 check_all("arst_now");
    chk("arst_now stall", 8'(stall), 8'd0); chk("arst_now fwd_rs_E", 8'(fwd_rs_E), 8'd0);
    tick();
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 2'd1);
    #2 reset = 1'b1;
    #1 check_all("rel_lw"); chk("rel_lw stall", 8'(stall), 8'd0); tick();
    set_d(5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0); #2 check_all("rel_beq");
    chk("rel_beq stall", 8'(stall), 8'd1); tick();
    for (int i = 0; i < 3; i++) begin i_nop(); #2 check_all("drain"); tick(); end

`ifdef HAZARD_MULDIV_EN
    begin
      int cnt;
      i_nop(); md_start_D = 1'b1; md_div_D = 1'b1; md_use_D = 1'b1;
      #2 check_all("div"); tick();
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 2'd0); md_use_D = 1'b1;
        #2 check_all("mflo");
        if (stall === 1'b1) cnt++;
        tick();
      end
      chk("div stall cycles", 8'(cnt), 8'd11);
      i_nop(); md_start_D = 1'b1; md_use_D = 1'b1;
      #2 check_all("mult"); tick();
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 2'd0); md_use_D = 1'b1;
        #2 check_all("mfhi");
        if (stall === 1'b1) cnt++;
        tick();
      end
      chk("mult stall cycles", 8'(cnt), 8'd6);
    end
`endif

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: set_d(pick(), pick(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'd0, 2'd0, 2'd0);
        1: set_d(pick(), pick(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(), 2'd1, 2'd0);
        2: set_d(pick(), pick(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(), 2'd2, 2'd1);
        3: set_d(pick(), pick(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'd31, 2'd0, 2'd2);
        default: set_d(pick(), pick(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'd0, 2'd0, 2'd0);
      endcase
      md_start_D = ($urandom_range(0, 7) == 0);
      md_div_D   = 1'($urandom_range(0, 1));
      md_use_D   = 1'($urandom_range(0, 1));
      #2 check_all("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
